// File: rtl/mux_pipeline_sequencer.sv
// Valid/ready sequencer wrapped around a pipelined mux that has no valid
// tracking of its own. One request is accepted, its select and input vector
// are held on the mux for the full pipeline depth, and the settled result is
// captured and offered downstream until it is taken.
module mux_pipeline_sequencer #(
  parameter int WIDTH       = 1,
  parameter int INPUT_COUNT = 2,
  parameter int LATENCY     = 0,
  parameter int SEL_W       = $clog2(INPUT_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SEL_W-1:0]             s_sel,
  input  logic [WIDTH*INPUT_COUNT-1:0] s_data,
  output logic [SEL_W-1:0]             mux_sel,
  output logic [WIDTH*INPUT_COUNT-1:0] mux_in,
  input  logic [WIDTH-1:0]             mux_out,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_err,
  output logic                         busy
);

  // Settling counter needs at least one bit even when the mux is purely
  // combinational (LATENCY == 0).
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_LOAD  = CNT_W'(LATENCY);
  // One extra bit so INPUT_COUNT itself is representable for the range test.
  localparam logic [SEL_W:0]   LP_SEL_LIMIT = (SEL_W + 1)'(INPUT_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_err;
  logic [SEL_W-1:0]               r_mux_sel;
  logic [WIDTH*INPUT_COUNT-1:0]   r_mux_in;
  logic [WIDTH-1:0]               r_m_data;
  logic                           r_m_valid;
  logic                           r_m_err;
  logic                           r_busy;

  logic                           w_s_ready;
  logic                           w_accept;
  logic                           w_retire;
  logic                           w_cnt_done;
  logic                           w_sel_err;

  // Handshake decode; s_ready is the only input-to-output combinational path.
  always_comb begin
    w_s_ready  = (r_state == S_IDLE) | ((r_state == S_HOLD) & m_ready);
    w_accept   = s_valid & w_s_ready;
    w_retire   = (r_state == S_HOLD) & m_ready;
    w_cnt_done = (r_state == S_WAIT) & (r_cnt == '0);
    w_sel_err  = ({1'b0, s_sel} >= LP_SEL_LIMIT);
  end

  // Next-state logic for the single in-flight transaction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (s_valid) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          w_state_nxt = s_valid ? S_WAIT : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with busy as a registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Request capture: the mux drive only changes on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_sel <= '0;
      r_mux_in  <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_mux_sel <= s_sel;
      r_mux_in  <= s_data;
      r_err     <= w_sel_err;
    end
  end

  // Settling counter: loaded with the pipeline depth, counts down in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= LP_CNT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result register: capture the settled mux output, hold it until taken.
  // A bad select still takes the full latency but reports zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_err   <= 1'b0;
    end else if (w_cnt_done) begin
      r_m_data  <= r_err ? '0 : mux_out;
      r_m_err   <= r_err;
      r_m_valid <= 1'b1;
    end else if (w_retire) begin
      r_m_valid <= 1'b0;
      r_m_err   <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign mux_sel = r_mux_sel;
  assign mux_in  = r_mux_in;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_err   = r_m_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mux_pipeline_sequencer.sv
// Directed bench for mux_pipeline_sequencer: a LATENCY=2 instance behind a
// two-stage mux model and a LATENCY=0 instance behind a combinational mux.
module tb_mux_pipeline_sequencer;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int SW = 3;

  logic clk;
  logic rst_n;

  // LATENCY=2 instance signals
  logic          s_valid, s_ready, m_valid, m_ready, m_err, busy;
  logic [SW-1:0] s_sel, mux_sel;
  logic [W*N-1:0] s_data, mux_in;
  logic [W-1:0]  mux_out, m_data;

  // LATENCY=0 instance signals
  logic          s_valid0, s_ready0, m_valid0, m_ready0, m_err0, busy0;
  logic [SW-1:0] s_sel0, mux_sel0;
  logic [W*N-1:0] mux_in0;
  logic [W-1:0]  mux_out0, m_data0;

  int n_checks = 0;
  int n_errors = 0;

  mux_pipeline_sequencer #(.WIDTH(W), .INPUT_COUNT(N), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel), .s_data(s_data),
    .mux_sel(mux_sel), .mux_in(mux_in), .mux_out(mux_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .busy(busy)
  );

  mux_pipeline_sequencer #(.WIDTH(W), .INPUT_COUNT(N), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_sel(s_sel0), .s_data(s_data),
    .mux_sel(mux_sel0), .mux_in(mux_in0), .mux_out(mux_out0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .m_err(m_err0),
    .busy(busy0)
  );

  // Mux model: out-of-range selects yield a poison value that must never leak.
  function automatic logic [W-1:0] mux_pick(input logic [W*N-1:0] v,
                                            input logic [SW-1:0] sel);
    if (sel < SW'(N)) return v[sel*W +: W];
    return 8'hEE;
  endfunction

  logic [W-1:0] mdl_p1, mdl_p2;
  always_ff @(posedge clk) begin
    mdl_p1 <= mux_pick(mux_in, mux_sel);
    mdl_p2 <= mdl_p1;
  end
  assign mux_out  = mdl_p2;
  assign mux_out0 = mux_pick(mux_in0, mux_sel0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] sels [3];
  logic [W-1:0]  exps [3];
  int hits;

  initial begin
    sels[0] = 3'd1; sels[1] = 3'd4; sels[2] = 3'd0;
    exps[0] = 8'h11; exps[1] = 8'h44; exps[2] = 8'h00;
    rst_n = 1'b1;
    s_valid = 0; s_sel = 0; m_ready = 0;
    s_valid0 = 0; s_sel0 = 0; m_ready0 = 0;
    s_data = 40'h44_33_22_11_00;

    // Reset asserted mid-clock: outputs clear without an edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_m_err",   m_err,   0);
    chk("rst_busy",    busy,    0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_mux_in",  mux_in,  0);
    chk("rst0_m_valid", m_valid0, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Single transaction, sel=3
    s_valid = 1; s_sel = 3;
    chk("idle_s_ready", s_ready, 1);
    tick; // E0
    s_valid = 0;
    chk("acc_mux_sel", mux_sel, 3);
    chk("acc_mux_in",  mux_in, 40'h44_33_22_11_00);
    chk("wait_s_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
    tick; chk("e1_m_valid", m_valid, 0);
    tick; chk("e2_m_valid", m_valid, 0);
    tick;
    chk("e3_m_valid", m_valid, 1);
    chk("e3_m_data", m_data, 8'h33);
    chk("e3_m_err", m_err, 0);

    // Backpressure for five cycles
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 8'h33);
      chk("bp_m_err", m_err, 0);
      chk("bp_busy", busy, 1);
      chk("bp_s_ready", s_ready, 0);
    end
    m_ready = 1;
    #1 chk("hold_rdy_s_ready", s_ready, 1);
    tick;
    chk("ret_m_valid", m_valid, 0);
    chk("ret_s_ready", s_ready, 1);
    chk("ret_busy", busy, 0);
    chk("ret_m_data_kept", m_data, 8'h33);

    // Back-to-back with continuous m_ready
    s_valid = 1; s_sel = sels[0];
    tick; // first accept
    for (int r = 0; r < 3; r++) begin
      if (r < 2) s_sel = sels[r+1];
      else s_valid = 0;
      tick; chk("b2b_c1_m_valid", m_valid, 0);
      tick; chk("b2b_c2_m_valid", m_valid, 0);
      tick;
      chk("b2b_m_valid", m_valid, 1);
      chk("b2b_m_data", m_data, exps[r]);
      chk("b2b_s_ready", s_ready, 1);
      tick; // retire, and accept of the next request when one is pending
      chk("b2b_drop_m_valid", m_valid, 0);
      if (r < 2) begin
        chk("b2b_next_sel", mux_sel, sels[r+1]);
        chk("b2b_busy", busy, 1);
      end else begin
        chk("b2b_end_busy", busy, 0);
      end
    end

    // Out-of-range select
    m_ready = 0;
    s_valid = 1; s_sel = 3'd6;
    tick; // E0
    s_valid = 0;
    tick; tick;
    chk("oor_e2_m_valid", m_valid, 0);
    tick;
    chk("oor_m_valid", m_valid, 1);
    chk("oor_m_data", m_data, 0);
    chk("oor_m_err", m_err, 1);
    s_valid = 1; s_sel = 3'd2; m_ready = 1;
    tick;
    s_valid = 0;
    chk("oor_clr_m_err", m_err, 0);
    chk("oor_clr_m_valid", m_valid, 0);
    chk("oor_next_sel", mux_sel, 2);
    tick; tick; tick;
    chk("legal_m_valid", m_valid, 1);
    chk("legal_m_data", m_data, 8'h22);
    chk("legal_m_err", m_err, 0);
    tick;
    m_ready = 0;

    // LATENCY=0 instance
    s_valid0 = 1; s_sel0 = 3'd4; m_ready0 = 1;
    tick; // E0
    s_valid0 = 0;
    chk("l0_e0_m_valid", m_valid0, 0);
    chk("l0_e0_busy", busy0, 1);
    tick;
    chk("l0_e1_m_valid", m_valid0, 1);
    chk("l0_e1_m_data", m_data0, 8'h44);
    tick;
    chk("l0_ret_m_valid", m_valid0, 0);

    // Reset abort one cycle after accept
    s_valid = 1; s_sel = 3'd3;
    tick; // E0
    s_valid = 0;
    tick;
    rst_n = 0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 1);
    chk("abort_mux_sel", mux_sel, 0);
    chk("abort_m_data", m_data, 0);
    tick;
    rst_n = 1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (m_valid !== 1'b0) hits++;
    end
    chk("abort_no_valid", hits, 0);
    chk("abort_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
